// File: rtl/bfp_pkg.sv
// bfp_pkg: shared types and helpers for the block-floating-point scale controller.
//   LZC_WIDTH   - default width of one leading-zero count / shift value
//   lzc_t       - one leading-zero count
//   bfp_state_e - frame sequencing states
//   sat_sub     - subtraction clamped at zero
package bfp_pkg;

    localparam int LZC_WIDTH = 5;

    typedef logic [LZC_WIDTH-1:0] lzc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } bfp_state_e;

    // a - b, clamped at zero instead of wrapping.
    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/min_detect_16in.sv
// min_detect_16in: registered minimum of 16 unsigned lanes.
//   clk, rstn - clock, asynchronous active-low reset
//   en        - capture the minimum of min_in this cycle
//   min_in    - 16 lane values
//   min_out   - minimum captured on the last enabled cycle (valid one cycle after en)
module min_detect_16in #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] min_in [16],
    output logic [W-1:0] min_out
);

    logic [W-1:0] min_comb;
    logic [W-1:0] min_q;

    always_comb begin
        min_comb = min_in[0];
        for (int i = 1; i < 16; i++) begin
            if (min_in[i] < min_comb) begin
                min_comb = min_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            min_q <= '0;
        end else if (en) begin
            min_q <= min_comb;
        end
    end

    assign min_out = min_q;

endmodule

// File: rtl/bfp_scale_ctrl.sv
// bfp_scale_ctrl: block-floating-point scale controller.
// Folds per-beat lane minima of leading-zero counts into a frame minimum,
// issues one normalisation shift per frame through a valid/ready handshake
// and accumulates a saturating block exponent across stages.
//   clk, rstn            - clock, asynchronous active-low reset
//   in_valid/in_ready    - beat handshake; in_lzc = 16 lane counts, in_last = frame end
//   scale_valid/ready    - shift result handshake
//   scale_shift          - min(max(frame_min - GUARD_BITS, 0), MAX_SHIFT)
//   frame_min, frame_err - raw frame minimum and frame length mismatch flag
//   blk_exp, exp_clr     - accumulated exponent and its synchronous clear
import bfp_pkg::*;

module bfp_scale_ctrl #(
    parameter int          LZC_WIDTH   = 5,
    parameter int          FRAME_BEATS = 32,
    parameter int unsigned GUARD_BITS  = 1,
    parameter int unsigned MAX_SHIFT   = 15,
    parameter int          EXP_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LZC_WIDTH-1:0] in_lzc [16],
    input  logic                 in_last,
    output logic                 scale_valid,
    input  logic                 scale_ready,
    output logic [LZC_WIDTH-1:0] scale_shift,
    output logic [LZC_WIDTH-1:0] frame_min,
    output logic                 frame_err,
    output logic [EXP_WIDTH-1:0] blk_exp,
    input  logic                 exp_clr
);

    bfp_state_e           state_q, state_d;
    logic [8:0]           beat_cnt_q, beat_cnt_d;
    logic [8:0]           beat_num;
    logic                 d_valid_q, d_first_q;
    logic [LZC_WIDTH-1:0] det_min;
    logic [LZC_WIDTH-1:0] run_min_q, run_min_d;
    logic                 err_pend_q;
    logic [LZC_WIDTH-1:0] scale_shift_q, scale_shift_d;
    logic [LZC_WIDTH-1:0] frame_min_q;
    logic                 frame_err_q;
    logic [EXP_WIDTH-1:0] blk_exp_q, blk_exp_d;
    logic                 accept, at_limit, end_beat, handshake;
    logic [EXP_WIDTH:0]   exp_sum;
    int unsigned          shift_raw;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign handshake = (state_q == HOLD) && scale_ready;

    // Number this beat would carry if accepted now.
    assign beat_num = (state_q == IDLE) ? 9'd1 : beat_cnt_q + 9'd1;
    assign at_limit = (beat_num == 9'(FRAME_BEATS));
    assign end_beat = accept && (in_last || at_limit);

    min_detect_16in #(.W(LZC_WIDTH)) u_min_detect (
        .clk     (clk),
        .rstn    (rstn),
        .en      (accept),
        .min_in  (in_lzc),
        .min_out (det_min)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            // A one-beat frame (in_last on beat 1) goes straight to DRAIN.
            IDLE: if (accept) begin
                beat_cnt_d = beat_num;
                state_d    = end_beat ? DRAIN : ACCUM;
            end
            ACCUM: if (accept) begin
                beat_cnt_d = beat_num;
                if (end_beat) state_d = DRAIN;
            end
            DRAIN: state_d = HOLD;
            HOLD: if (scale_ready) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fold the detector output; in DRAIN this already includes the final beat.
    always_comb begin
        run_min_d = run_min_q;
        if (d_valid_q) begin
            if (d_first_q || (det_min < run_min_q)) begin
                run_min_d = det_min;
            end
        end
    end

    always_comb begin
        shift_raw     = sat_sub(32'(run_min_d), GUARD_BITS);
        scale_shift_d = (shift_raw > MAX_SHIFT) ? LZC_WIDTH'(MAX_SHIFT) : LZC_WIDTH'(shift_raw);
    end

    always_comb begin
        exp_sum   = {1'b0, blk_exp_q} + (EXP_WIDTH+1)'(scale_shift_q);
        blk_exp_d = blk_exp_q;
        if (exp_clr && handshake) begin
            blk_exp_d = EXP_WIDTH'(scale_shift_q);
        end else if (exp_clr) begin
            blk_exp_d = '0;
        end else if (handshake) begin
            blk_exp_d = exp_sum[EXP_WIDTH] ? '1 : exp_sum[EXP_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            d_valid_q     <= 1'b0;
            d_first_q     <= 1'b0;
            run_min_q     <= '0;
            err_pend_q    <= 1'b0;
            scale_shift_q <= '0;
            frame_min_q   <= '0;
            frame_err_q   <= 1'b0;
            blk_exp_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            d_valid_q  <= accept;
            d_first_q  <= accept && (state_q == IDLE);
            run_min_q  <= run_min_d;
            blk_exp_q  <= blk_exp_d;
            // Length mismatch: in_last early, or the limit reached without in_last.
            if (end_beat) begin
                err_pend_q <= in_last ^ at_limit;
            end
            if (state_q == DRAIN) begin
                frame_min_q   <= run_min_d;
                scale_shift_q <= scale_shift_d;
                frame_err_q   <= err_pend_q;
            end
        end
    end

    assign scale_valid = (state_q == HOLD);
    assign scale_shift = scale_shift_q;
    assign frame_min   = frame_min_q;
    assign frame_err   = frame_err_q;
    assign blk_exp     = blk_exp_q;

endmodule

// File: tb/tb_bfp_scale_ctrl.sv
module tb_bfp_scale_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_lzc [16];
    logic       in_last;
    logic       scale_valid;
    logic       scale_ready;
    logic [4:0] scale_shift;
    logic [4:0] frame_min;
    logic       frame_err;
    logic [7:0] blk_exp;
    logic       exp_clr;

    int checks   = 0;
    int failures = 0;
    int blk_model = 0;

    typedef struct {
        int fill;      // value on every lane
        int sp_beat;   // beat carrying one special lane (0 = none)
        int sp_lane;
        int sp_val;
        int nbeats;    // beats driven
        bit last_on;   // in_last on the final driven beat
        bit bubbles;   // idle cycle between beats
        bit extra;     // keep offering one more beat during DRAIN/HOLD
        int delay;     // cycles of scale_ready=0 before accepting
        bit clr;       // exp_clr together with the handshake
        int exp_min;
        int exp_shift;
        bit exp_err;
    } vec_t;

    typedef struct {
        int min_v;
        int shift;
        bit err;
        bit clr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    bfp_scale_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lzc      (in_lzc),
        .in_last     (in_last),
        .scale_valid (scale_valid),
        .scale_ready (scale_ready),
        .scale_shift (scale_shift),
        .frame_min   (frame_min),
        .frame_err   (frame_err),
        .blk_exp     (blk_exp),
        .exp_clr     (exp_clr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int v);
        for (int l = 0; l < 16; l++) in_lzc[l] = 5'(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},    32'(in_ready),    1);
        chk({tag, "_scale_valid"}, 32'(scale_valid), 0);
        chk({tag, "_scale_shift"}, 32'(scale_shift), 0);
        chk({tag, "_frame_min"},   32'(frame_min),   0);
        chk({tag, "_frame_err"},   32'(frame_err),   0);
        chk({tag, "_blk_exp"},     32'(blk_exp),     0);
    endtask

    // Drive one beat, waiting (bounded) for in_ready.
    task automatic drive_beat(input int b, input vec_t v);
        int n = 0;
        for (int l = 0; l < 16; l++)
            in_lzc[l] = (b == v.sp_beat && l == v.sp_lane) ? 5'(v.sp_val) : 5'(v.fill);
        in_last  = v.last_on && (b == v.nbeats);
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("beat_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        set_lanes(0);
    endtask

    task automatic run_frame(input vec_t v);
        exp_t e;
        e.min_v = v.exp_min;
        e.shift = v.exp_shift;
        e.err   = v.exp_err;
        e.clr   = v.clr;
        sb.push_back(e);
        for (int b = 1; b <= v.nbeats; b++) begin
            drive_beat(b, v);
            if (v.bubbles && b < v.nbeats) tick();
        end
        // DRAIN cycle (T+1)
        chk("drain_scale_valid", 32'(scale_valid), 0);
        chk("drain_in_ready",    32'(in_ready),    0);
        if (v.extra) begin
            set_lanes(0);
            in_valid = 1'b1;
        end
        tick();
        // HOLD from T+2
        chk("latency_scale_valid", 32'(scale_valid), 1);
        for (int d = 0; d < v.delay; d++) begin
            chk("bp_in_ready",    32'(in_ready),    0);
            chk("bp_scale_valid", 32'(scale_valid), 1);
            chk("bp_frame_min",   32'(frame_min),   32'(sb[0].min_v));
            chk("bp_scale_shift", 32'(scale_shift), 32'(sb[0].shift));
            chk("bp_blk_exp",     32'(blk_exp),     32'(blk_model));
            tick();
        end
        chk("hold_in_ready", 32'(in_ready), 0);
        e = sb.pop_front();
        chk("frame_min",   32'(frame_min),   32'(e.min_v));
        chk("scale_shift", 32'(scale_shift), 32'(e.shift));
        chk("frame_err",   32'(frame_err),   32'(e.err));
        scale_ready = 1'b1;
        exp_clr     = e.clr;
        tick();
        scale_ready = 1'b0;
        exp_clr     = 1'b0;
        in_valid    = 1'b0;
        if (e.clr) blk_model = e.shift;
        else       blk_model = (blk_model + e.shift > 255) ? 255 : blk_model + e.shift;
        chk("post_blk_exp",     32'(blk_exp),     32'(blk_model));
        chk("post_scale_valid", 32'(scale_valid), 0);
        chk("post_in_ready",    32'(in_ready),    1);
        $display("frame fill=%0d beats=%0d min=%0d shift=%0d err=%0d blk_exp=%0d",
                 v.fill, v.nbeats, frame_min, scale_shift, frame_err, blk_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //        fill sp_b ln val  n last bub ext dly clr  min sh err
        vecs[0] = '{9,  17, 5, 3, 32, 1, 0, 0, 0,  0,  3,  2, 0}; // nominal
        vecs[1] = '{9,  17, 5, 3, 32, 1, 0, 0, 10, 0,  3,  2, 0}; // back-pressure
        vecs[2] = '{31, 0,  0, 0, 32, 1, 0, 0, 0,  0,  31, 15, 0}; // clamp
        vecs[3] = '{0,  0,  0, 0, 32, 1, 0, 0, 0,  0,  0,  0, 0}; // zero floor
        vecs[4] = '{7,  0,  0, 0, 20, 1, 0, 0, 2,  0,  7,  6, 1}; // early in_last
        vecs[5] = '{5,  0,  0, 0, 32, 0, 0, 1, 3,  0,  5,  4, 1}; // forced end, beat 33 stalls
        vecs[6] = '{9,  17, 5, 3, 32, 1, 1, 0, 0,  0,  3,  2, 0}; // bubbles
        vecs[7] = '{5,  0,  0, 0, 32, 1, 0, 0, 0,  1,  5,  4, 0}; // clear with handshake

        rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        scale_ready = 1'b0; exp_clr = 1'b0;
        set_lanes(0);
        #1;
        check_reset_outputs("reset");
        tick(); tick();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Twenty shift-15 frames saturate the exponent.
        v = vecs[2];
        for (int i = 0; i < 20; i++) run_frame(v);
        chk("blk_exp_saturated", 32'(blk_exp), 255);

        // Reset pulsed after beat 10 of a low-valued frame aborts it.
        v = '{1, 0, 0, 0, 32, 1, 0, 0, 0, 0, 1, 0, 0};
        for (int b = 1; b <= 10; b++) drive_beat(b, v);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        blk_model = 0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        v = '{6, 0, 0, 0, 32, 1, 0, 0, 0, 0, 6, 5, 0};
        run_frame(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
